// File: rtl/dfe_pkg.sv
// Shared constants and helpers for the PAM-4 decision-feedback equalizer:
// ideal levels, slicer thresholds, Q0.8 tap weights and the saturate helper.
package dfe_pkg;

  localparam int H_FRAC_BITS = 8;
  localparam int MAX_TAPS    = 4;

  // Unsigned Q0.8 post-cursor weights, H[1] is the most recent decision's tap.
  localparam logic [7:0] H_TAPS [1:MAX_TAPS] = '{8'd128, 8'd64, 8'd32, 8'd16};

  localparam int THR_MID = 0;

  function automatic int level_outer(input int s);
    return (3 * s) / 2;
  endfunction

  function automatic int level_inner(input int s);
    return s / 2;
  endfunction

  function automatic int thr_hi(input int s);
    return s;
  endfunction

  function automatic int thr_lo(input int s);
    return -s;
  endfunction

  // Clamp a signed value into the two's-complement range of the given width.
  function automatic int saturate(input int value, input int width);
    int hi;
    int lo;
    hi = (1 << (width - 1)) - 1;
    lo = -(1 << (width - 1));
    if (value > hi)      return hi;
    else if (value < lo) return lo;
    else                 return value;
  endfunction

endpackage

// File: rtl/pam4_slicer.sv
// Combinational PAM-4 slicer: maps an equalized sample to the nearest
// ideal level at thresholds -S, 0, +S.
module pam4_slicer
  import dfe_pkg::*;
#(
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int SYMBOL_SEPERATION = 56
) (
  input  logic signed [SIGNAL_RESOLUTION-1:0] eq_i,
  output logic signed [SIGNAL_RESOLUTION-1:0] level_o
);

  localparam int S = SYMBOL_SEPERATION;

  always_comb begin
    // NOTE: every branch assigns level_o, so no latch is inferred.
    if (int'(eq_i) >= thr_hi(S))
      level_o = SIGNAL_RESOLUTION'(level_outer(S));
    else if (int'(eq_i) >= THR_MID)
      level_o = SIGNAL_RESOLUTION'(level_inner(S));
    else if (int'(eq_i) >= thr_lo(S))
      level_o = SIGNAL_RESOLUTION'(-level_inner(S));
    else
      level_o = SIGNAL_RESOLUTION'(-level_outer(S));
  end

endmodule

// File: rtl/dfe.sv
// PAM-4 decision-feedback equalizer. Feedback taps are built only when
// DFE_FEEDBACK_EN is defined; otherwise this is a registered slicer.
module dfe
  import dfe_pkg::*;
#(
  parameter int PULSE_RESPONSE_LENGTH = 2,
  parameter int SIGNAL_RESOLUTION     = 8,
  parameter int SYMBOL_SEPERATION     = 56
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic signed [SIGNAL_RESOLUTION-1:0] signal_in,
  input  logic                                signal_in_valid,
  output logic signed [SIGNAL_RESOLUTION-1:0] signal_out,
  output logic                                signal_out_valid
);

  localparam int N  = SIGNAL_RESOLUTION;
  localparam int SW = N + 9 + $clog2(PULSE_RESPONSE_LENGTH);

  logic signed [SW-1:0] fb;
  logic signed [SW:0]   eq_ext;
  logic signed [N-1:0]  eq_sat;
  logic signed [N-1:0]  decision;
  logic signed [N-1:0]  signal_out_q;
  logic                 valid_q;

`ifdef DFE_FEEDBACK_EN
  localparam int TAPS = PULSE_RESPONSE_LENGTH - 1;

  if (TAPS > 0) begin : g_feedback
    // hist_q[0] holds d[1], the most recent decision.
    logic signed [N-1:0]  hist_q [TAPS];
    logic signed [SW-1:0] acc;
    logic signed [SW-1:0] h_ext;
    logic signed [SW-1:0] d_ext;

    always_comb begin
      acc   = '0;
      h_ext = '0;
      d_ext = '0;
      for (int k = 0; k < TAPS; k++) begin
        h_ext = SW'($signed({1'b0, H_TAPS[k+1]}));
        d_ext = SW'(hist_q[k]);
        acc   = acc + h_ext * d_ext;
      end
      fb = acc >>> H_FRAC_BITS;
    end

    // NOTE: the history is a handful of flops feeding the multipliers, and it
    // must read as zero right after reset, so every entry is reset here.
    always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
        for (int k = 0; k < TAPS; k++) hist_q[k] <= '0;
      end else if (signal_in_valid) begin
        hist_q[0] <= decision;
        for (int k = 1; k < TAPS; k++) hist_q[k] <= hist_q[k-1];
      end
    end
  end else begin : g_no_taps
    assign fb = '0;
  end
`else
  assign fb = '0;
`endif

  assign eq_ext = (SW+1)'(signal_in) - (SW+1)'(fb);
  assign eq_sat = N'(saturate(int'(eq_ext), N));

  pam4_slicer #(
    .SIGNAL_RESOLUTION (SIGNAL_RESOLUTION),
    .SYMBOL_SEPERATION (SYMBOL_SEPERATION)
  ) u_slicer (
    .eq_i    (eq_sat),
    .level_o (decision)
  );

  // NOTE: registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      signal_out_q <= '0;
      valid_q      <= 1'b0;
    end else begin
      valid_q <= signal_in_valid;
      if (signal_in_valid) signal_out_q <= decision;
    end
  end

  assign signal_out       = signal_out_q;
  assign signal_out_valid = valid_q;

endmodule

// File: tb/tb_dfe.sv
// Directed self-checking bench for dfe; expectations follow whichever
// DFE_FEEDBACK_EN setting the bundle is compiled with.
module tb_dfe;

`ifdef DFE_FEEDBACK_EN
  localparam bit FB = 1'b1;
`else
  localparam bit FB = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rstn = 1'b1;
  logic signed [7:0] signal_in = '0;
  logic              signal_in_valid = 1'b0;
  logic signed [7:0] signal_out;
  logic              signal_out_valid;

  int checks   = 0;
  int failures = 0;

  dfe #(
    .PULSE_RESPONSE_LENGTH (2),
    .SIGNAL_RESOLUTION     (8),
    .SYMBOL_SEPERATION     (56)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .signal_in        (signal_in),
    .signal_in_valid  (signal_in_valid),
    .signal_out       (signal_out),
    .signal_out_valid (signal_out_valid)
  );

  always #5 clk = ~clk;

  // Apply one input away from the edge, then sample just after the edge.
  task automatic drive(input int s, input logic v);
    @(negedge clk);
    signal_in       = 8'(s);
    signal_in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      drive(int'($urandom_range(0, 255)) - 128, 1'(($urandom_range(0, 1))));
      checks++;
      if (signal_out !== 8'sd0 || signal_out_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold[%0d]: got out=%0d valid=%b, want out=0 valid=0",
                 i, signal_out, signal_out_valid);
      end
    end
    @(negedge clk);
    rstn = 1'b0;
    drive(84, 1'b1);
    checks++;
    if (signal_out !== 8'sd84 || signal_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL first_after_reset: got out=%0d valid=%b, want out=84 valid=1",
               signal_out, signal_out_valid);
    end
  endtask

  // History d[1] = +84 on entry.
  task automatic test_isi_cancel();
    int exp;
    exp = FB ? -28 : 28;
    drive(14, 1'b1);
    checks++;
    if (signal_out !== 8'(exp) || signal_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL isi_cancel: got out=%0d valid=%b, want out=%0d valid=1",
               signal_out, signal_out_valid, exp);
    end
  endtask

  // History d[1] = -28 (feedback) or +28 (no feedback) on entry.
  task automatic test_thresholds();
    int vin [5]  = '{14, 70, 70, 69, 14};
    int e_on [5] = '{28, 84, 28, 28, 28};
    int e_off[5] = '{28, 84, 84, 84, 28};
    for (int i = 0; i < 5; i++) begin
      drive(vin[i], 1'b1);
      checks++;
      if (signal_out !== 8'(FB ? e_on[i] : e_off[i])) begin
        failures++;
        $display("FAIL threshold[%0d] in=%0d: got %0d, want %0d",
                 i, vin[i], signal_out, FB ? e_on[i] : e_off[i]);
      end
    end
  endtask

  // History d[1] = +28 on entry; drives both saturation rails.
  task automatic test_saturation();
    int vin [4]  = '{-128, 127, 127, -128};
    int e_on [4] = '{-84, 84, 84, -84};
    int e_off[4] = '{-84, 84, 84, -84};
    for (int i = 0; i < 4; i++) begin
      drive(vin[i], 1'b1);
      checks++;
      if (signal_out !== 8'(FB ? e_on[i] : e_off[i])) begin
        failures++;
        $display("FAIL saturation[%0d] in=%0d: got %0d, want %0d",
                 i, vin[i], signal_out, FB ? e_on[i] : e_off[i]);
      end
    end
  endtask

  task automatic test_valid_gaps();
    int   vin [5] = '{84, -100, 127, 14, 100};
    logic vv  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    int   e_out[5];
    e_out = '{84, 84, 84, FB ? -28 : 28, FB ? -28 : 28};
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      drive(vin[i], vv[i]);
      checks++;
      if (signal_out !== 8'(e_out[i]) || signal_out_valid !== vv[i]) begin
        failures++;
        $display("FAIL valid_gap[%0d]: got out=%0d valid=%b, want out=%0d valid=%b",
                 i, signal_out, signal_out_valid, e_out[i], vv[i]);
      end
    end
  endtask

  // History d[1] = -28 (feedback) or +28 (no feedback) on entry.
  task automatic test_reset_midstream();
    drive(84, 1'b1);
    checks++;
    if (signal_out !== 8'sd84) begin
      failures++;
      $display("FAIL midreset_pre: got %0d, want 84", signal_out);
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checks++;
    if (signal_out !== 8'sd0 || signal_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_async: got out=%0d valid=%b, want out=0 valid=0",
               signal_out, signal_out_valid);
    end
    @(negedge clk);
    rstn = 1'b0;
    drive(14, 1'b1);
    checks++;
    if (signal_out !== 8'sd28 || signal_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL midreset_cleared: got out=%0d valid=%b, want out=28 valid=1",
               signal_out, signal_out_valid);
    end
  endtask

  // History d[1] = +28 on entry; consecutive valid samples, incl. eq = -S.
  task automatic test_back_to_back();
    int vin [6]  = '{-20, 50, -60, 0, -42, -71};
    int e_on [6] = '{-28, 84, -84, 28, -28, -84};
    int e_off[6] = '{-28, 28, -84, 28, -28, -84};
    for (int i = 0; i < 6; i++) begin
      drive(vin[i], 1'b1);
      checks++;
      if (signal_out !== 8'(FB ? e_on[i] : e_off[i]) || signal_out_valid !== 1'b1) begin
        failures++;
        $display("FAIL back_to_back[%0d] in=%0d: got out=%0d valid=%b, want out=%0d valid=1",
                 i, vin[i], signal_out, signal_out_valid, FB ? e_on[i] : e_off[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_isi_cancel();
    test_thresholds();
    test_saturation();
    test_valid_gaps();
    test_reset_midstream();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dfe.md
# dfe

PAM-4 receive-side decision-feedback equalizer. It takes signed voltage samples from the ISI channel model, subtracts the post-cursor inter-symbol interference predicted from its own past decisions, and slices the result to the nearest ideal PAM-4 level. It sits between `ISI_channel` and the Rx symbol decoder, closing the Tx → channel → Rx loop.

## Interface
- `PULSE_RESPONSE_LENGTH`, default 2: channel pulse-response length (cursor plus post-cursors), range 1..5. Feedback tap count is `PULSE_RESPONSE_LENGTH-1`.
- `SIGNAL_RESOLUTION`, default 8: sample width in bits, signed two's complement.
- `SYMBOL_SEPERATION`, default 56: spacing between adjacent ideal PAM-4 levels.
- `clk` in 1: the single clock; all logic rises on posedge.
- `rstn` in 1: reset, asynchronous, active-high (1 = reset).
- `signal_in` in `SIGNAL_RESOLUTION`: received sample, signed.
- `signal_in_valid` in 1: `signal_in` qualifier.
- `signal_out` out `SIGNAL_RESOLUTION`: decided ideal level, signed.
- `signal_out_valid` out 1: `signal_out` qualifier.

## Operation
- Ideal levels with S = `SYMBOL_SEPERATION`: −3S/2, −S/2, +S/2, +3S/2. With defaults these are −84, −28, +28, +84.
- Slicer thresholds are −S, 0, +S.
  - eq ≥ S → +3S/2.
  - 0 ≤ eq < S → +S/2.
  - −S ≤ eq < 0 → −S/2.
  - eq < −S → −3S/2.
- Decision history d[1..L−1] holds past decided levels, d[1] most recent. Reset value of every entry is 0.
- Tap weights H[k], k = 1..L−1, are unsigned Q0.8 constants (value/256). Defaults: H[1]=128 (0.5), H[2]=64, H[3]=32, H[4]=16.
- Feedback: fb = Σ H[k]·d[k].
  - Full-precision signed sum of width `SIGNAL_RESOLUTION`+9+⌈log2 L⌉.
  - Then arithmetic shift right by 8 (floor).
- Equalized value: eq = `signal_in` − fb.
  - Computed at extended width.
  - Saturated to [−2^(N−1), 2^(N−1)−1] before slicing.
- On a cycle with `signal_in_valid`=1:
  - `signal_out` ← slice(eq).
  - History shifts: d[1] ← new decision, d[k] ← d[k−1].
- On a cycle with `signal_in_valid`=0:
  - History is frozen.
  - `signal_out` holds its last value.
- L = 1: no taps, so fb = 0 and the block is a pure slicer.

## Timing
- Reset values: `signal_out`=0, `signal_out_valid`=0, all history 0. Reset takes effect immediately (asynchronous), including mid-stream.
- Latency is 1 clock: a sample accepted at edge n appears on `signal_out` after edge n, with `signal_out_valid` = registered `signal_in_valid`.
- No backpressure. A sample is accepted on every valid cycle, back-to-back.
- Feedback path (history → multiply → subtract → slice → history) completes within one cycle. The decision from sample n is applied to sample n+1 even on consecutive valid cycles.
- The first sample after reset sees fb = 0.

## Configuration
- `DFE_FEEDBACK_EN` defined: feedback operates as described above.
- `DFE_FEEDBACK_EN` undefined:
  - fb is forced to 0 and no history registers or multipliers are built.
  - The block is a registered slicer with the same latency and ports.

## Structure
- Package `dfe_pkg` holds:
  - the level constants as functions of S;
  - the slicer thresholds;
  - the tap weight array H[1..4];
  - the saturate helper function.
- One sub-module: `pam4_slicer`, combinational: eq in → ideal level out, parameterized by `SIGNAL_RESOLUTION` and `SYMBOL_SEPERATION`.

## Test plan
All scenarios use default parameters and `DFE_FEEDBACK_EN` defined unless noted.
- Reset: hold `rstn`=1 with random `signal_in`/valid → `signal_out`=0, `signal_out_valid`=0. Release, first valid input +84 → `signal_out`=+84 one cycle later (fb = 0).
- ISI cancel: decisions +84, then input 14 (−28 + 0.5·84) → eq = −28 → `signal_out`=−28. With `DFE_FEEDBACK_EN` undefined, the same input → +28.
- Threshold boundaries, previous decision +28 (fb = 14):
  - input 70 → eq 56 → +84.
  - input 69 → eq 55 → +28.
  - input 14 → eq 0 → +28.
- Saturation: previous decision −84 (fb = −42), input 127 → eq clamps to 127 → +84, with no wrap to a negative level.
- Valid gaps: valid pattern 1,0,0,1 with inputs +84, junk, junk, 14 → second output is −28. Output and history are unchanged during gaps, and `signal_out_valid` follows the valid pattern delayed by one cycle.
- Reset mid-stream: after decision +84, assert `rstn` for one cycle, then input 14 → +28 (history was cleared).
